// File: rtl/fnd_scan_capture.sv
// fnd_scan_capture: watches a multiplexed active-low 4-digit seven-segment bus,
// filters scan glitches, decodes each font back to a hex nibble and delivers
// completed 16-bit frames over a valid/ready interface.
module fnd_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_digit,
    input  logic [7:0]  i_fndFont,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_value,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_fontErr,
    output logic        o_overrun,
    output logic        o_timeout
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

    // Returns {error, nibble}; the dp bit is forced high before matching.
    function automatic logic [4:0] decode_font(input logic [6:0] seg);
        logic [4:0] res;
        case ({1'b1, seg})
            8'hC0:   res = 5'h00;
            8'hF9:   res = 5'h01;
            8'hA4:   res = 5'h02;
            8'hB0:   res = 5'h03;
            8'h99:   res = 5'h04;
            8'h92:   res = 5'h05;
            8'h82:   res = 5'h06;
            8'hF8:   res = 5'h07;
            8'h80:   res = 5'h08;
            8'h90:   res = 5'h09;
            8'h88:   res = 5'h0A;
            8'h83:   res = 5'h0B;
            8'hC6:   res = 5'h0C;
            8'hA1:   res = 5'h0D;
            8'h86:   res = 5'h0E;
            8'h8E:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [11:0]      r_sync1;
    logic [11:0]      r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             w_same;
    logic             w_dig_valid;
    logic             w_accept;
    logic [3:0]       w_dig_sel;
    logic [4:0]       w_new_dec;
    logic             w_new_dp;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_mask;
    logic [3:0]       w_mask_next;
    logic [TO_W-1:0]  r_idle;
    logic [TO_W-1:0]  w_idle_next;
    logic             w_complete;
    logic             w_timeout_hit;
    logic             w_free;

    logic [15:0]      w_frame_value;
    logic [3:0]       w_frame_dp;
    logic [3:0]       w_frame_err;

    logic             r_valid;
    logic [15:0]      r_value;
    logic [3:0]       r_dp;
    logic [3:0]       r_font_err;
    logic             r_overrun;
    logic             r_timeout;

    assign w_same    = (r_sync1 == r_s2);
    assign w_dig_sel = ~r_s2[11:8];
    assign w_new_dec = decode_font(r_s2[6:0]);
    assign w_new_dp  = ~r_s2[7];
    // Fires on the edge where the stable count reaches SETTLE_CYCLES-1.
    assign w_accept  = w_dig_valid && w_same &&
                       (r_cnt == CNT_W'(SETTLE_CYCLES - 2));
    assign w_free    = !r_valid || i_ready;

    // Two-flop synchronizer and saturating stability counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_s2    <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {i_digit, i_fndFont};
            r_s2    <= r_sync1;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_W'(SETTLE_CYCLES))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Only single-active digit patterns are meaningful; blank and multi-active are ignored.
    always_comb begin
        w_dig_valid = 1'b0;
        case (r_s2[11:8])
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_dig_valid = 1'b1;
            default:                            w_dig_valid = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] r_nib;
            logic       r_dp_st;
            logic       r_err_st;

            // Per-digit store; the latest accepted font for this digit wins.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_nib    <= '0;
                    r_dp_st  <= 1'b0;
                    r_err_st <= 1'b0;
                end else if (w_accept && w_dig_sel[gi]) begin
                    r_nib    <= w_new_dec[3:0];
                    r_dp_st  <= w_new_dp;
                    r_err_st <= w_new_dec[4];
                end
            end

            // Frame view includes the digit being accepted on this same edge.
            assign w_frame_value[gi*4 +: 4] = (w_accept && w_dig_sel[gi]) ? w_new_dec[3:0] : r_nib;
            assign w_frame_dp[gi]           = (w_accept && w_dig_sel[gi]) ? w_new_dp       : r_dp_st;
            assign w_frame_err[gi]          = (w_accept && w_dig_sel[gi]) ? w_new_dec[4]   : r_err_st;
        end
    endgenerate

    // Frame FSM state, capture mask and idle timer registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            r_idle  <= w_idle_next;
        end
    end

    // Next-state logic: collect digits, detect completion and idle timeout.
    always_comb begin
        w_state_next  = r_state;
        w_mask_next   = r_mask;
        w_idle_next   = r_idle;
        w_complete    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mask_next = '0;
                w_idle_next = '0;
                if (w_accept) begin
                    w_mask_next  = w_dig_sel;
                    w_state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    w_idle_next = '0;
                    if ((r_mask | w_dig_sel) == 4'hF) begin
                        w_complete   = 1'b1;
                        w_mask_next  = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_mask_next = r_mask | w_dig_sel;
                    end
                end else if (r_idle == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_mask_next   = '0;
                    w_idle_next   = '0;
                    w_state_next  = ST_IDLE;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_mask_next  = '0;
                w_idle_next  = '0;
            end
        endcase
    end

    // Output holding register with valid/ready handshake and event pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid    <= 1'b0;
            r_value    <= '0;
            r_dp       <= '0;
            r_font_err <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overrun <= w_complete && !w_free;
            r_timeout <= w_timeout_hit;
            if (w_complete && w_free) begin
                r_valid    <= 1'b1;
                r_value    <= w_frame_value;
                r_dp       <= w_frame_dp;
                r_font_err <= w_frame_err;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_value   = r_value;
    assign o_dp      = r_dp;
    assign o_fontErr = r_font_err;
    assign o_overrun = r_overrun;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Scoreboard bench for fnd_scan_capture: directed scenarios followed by
// randomized scans, checked against a digit-level reference model.
module tb_fnd_scan_capture;
    localparam int SETTLE = 4;
    localparam int TO     = 50;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dig   = 4'hF;
    logic [7:0]  font  = 8'hFF;
    logic        ready = 1'b1;
    logic        o_valid;
    logic [15:0] o_value;
    logic [3:0]  o_dp;
    logic [3:0]  o_fontErr;
    logic        o_overrun;
    logic        o_timeout;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reference model state
    logic [3:0] m_nib [4];
    logic [3:0] m_dp;
    logic [3:0] m_err;
    logic [3:0] m_mask = 4'h0;
    int         m_last = 0;
    bit         m_held = 1'b0;

    frame_t exp_q[$];
    int     exp_to[$];
    int     exp_ov[$];
    int     obs_to[$];
    int     obs_ov[$];

    fnd_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_digit   (dig),
        .i_fndFont (font),
        .i_ready   (ready),
        .o_valid   (o_valid),
        .o_value   (o_value),
        .o_dp      (o_dp),
        .o_fontErr (o_fontErr),
        .o_overrun (o_overrun),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {err, nibble} by searching the hex font table with dp forced off
    function automatic logic [4:0] ref_decode(input logic [7:0] f);
        for (int k = 0; k < 16; k++)
            if (font_tbl[k] == (f | 8'h80)) return {1'b0, 4'(k)};
        return 5'h10;
    endfunction

    // A partial frame dies TO cycles after its last accepted digit, unless a
    // digit is accepted on exactly that cycle.
    task automatic model_timeout(input int t, input bit at_accept);
        if (m_mask != 4'h0 && (t - m_last) >= TO + (at_accept ? 1 : 0)) begin
            exp_to.push_back(m_last + TO);
            m_mask = 4'h0;
        end
    endtask

    task automatic model_accept(input int idx, input logic [7:0] f, input int t);
        logic [4:0] r;
        frame_t fr;
        model_timeout(t, 1'b1);
        r = ref_decode(f);
        m_nib[idx] = r[3:0];
        m_err[idx] = r[4];
        m_dp[idx]  = ~f[7];
        m_mask[idx] = 1'b1;
        m_last = t;
        if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            fr.v   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            fr.dp  = m_dp;
            fr.err = m_err;
            if (m_held && !ready) exp_ov.push_back(t);
            else begin
                exp_q.push_back(fr);
                m_held = !ready;
            end
        end
    endtask

    // Called right after a negedge: holds a pair for `hold` samples, then blank for `gap`.
    task automatic present(input logic [3:0] d, input logic [7:0] f, input int hold, input int gap);
        int idx;
        dig  = d;
        font = f;
        idx  = -1;
        for (int k = 0; k < 4; k++)
            if (d == ~(4'(1) << k)) idx = k;
        if (idx >= 0 && hold >= SETTLE) model_accept(idx, f, cyc + 1 + SETTLE);
        repeat (hold) @(negedge clk);
        if (gap > 0) begin
            dig  = 4'hF;
            font = 8'hFF;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic scan4(input logic [7:0] f3, input logic [7:0] f2, input logic [7:0] f1, input logic [7:0] f0);
        present(4'b1110, f0, 10, 1);
        present(4'b1101, f1, 10, 1);
        present(4'b1011, f2, 10, 1);
        present(4'b0111, f3, 10, 1);
    endtask

    // Monitor: pops the scoreboard on every handshake, logs event pulses,
    // and checks the held output does not move under backpressure.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] held_v     = '0;
    logic [3:0]  held_dp    = '0;
    logic [3:0]  held_err   = '0;
    int          n_frames   = 0;
    always begin
        frame_t e;
        @(negedge clk);
        #1;
        if (o_timeout) obs_to.push_back(cyc);
        if (o_overrun) obs_ov.push_back(cyc);
        if (o_valid && prev_valid && !prev_ready) begin
            chk("held_value", {16'h0, o_value}, {16'h0, held_v});
            chk("held_dp_err", {24'h0, o_dp, o_fontErr}, {24'h0, held_dp, held_err});
        end
        if (o_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {16'h0, o_value}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                n_frames++;
                $display("frame %0d @%0d: value=%h dp=%b err=%b (exp %h %b %b)",
                         n_frames, cyc, o_value, o_dp, o_fontErr, e.v, e.dp, e.err);
                chk("frame_value", {16'h0, o_value}, {16'h0, e.v});
                chk("frame_dp", {28'h0, o_dp}, {28'h0, e.dp});
                chk("frame_fontErr", {28'h0, o_fontErr}, {28'h0, e.err});
            end
        end
        prev_valid = o_valid;
        prev_ready = ready;
        held_v     = o_value;
        held_dp    = o_dp;
        held_err   = o_fontErr;
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
        chk({tag, "_value"}, {16'h0, o_value}, 32'h0);
        chk({tag, "_dp"}, {28'h0, o_dp}, 32'h0);
        chk({tag, "_fontErr"}, {28'h0, o_fontErr}, 32'h0);
        chk({tag, "_overrun"}, {31'h0, o_overrun}, 32'h0);
        chk({tag, "_timeout"}, {31'h0, o_timeout}, 32'h0);
    endtask

    initial begin
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // slow scan -> 4321
        ready = 1'b1;
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);

        // glitch digit1/8E for 3 samples between valid digits -> 3210
        present(4'b1110, 8'hC0, 10, 1);
        present(4'b1101, 8'hF9, 10, 1);
        present(4'b1101, 8'h8E, 3, 1);
        present(4'b1011, 8'hA4, 10, 1);
        present(4'b0111, 8'hB0, 10, 1);

        // bad font then overwrite with 8+dp; then bad font alone
        present(4'b1011, 8'h7F, 10, 1);
        present(4'b1011, 8'h00, 10, 1);
        present(4'b1110, 8'hC0, 10, 1);
        present(4'b1101, 8'hC0, 10, 1);
        present(4'b0111, 8'hC0, 10, 1);
        present(4'b1011, 8'hFF, 10, 1);
        present(4'b1110, 8'hC0, 10, 1);
        present(4'b1101, 8'hC0, 10, 1);
        present(4'b0111, 8'hC0, 10, 1);

        // backpressure: 1234 held, 5678 dropped with overrun
        ready = 1'b0;
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        scan4(8'h92, 8'h82, 8'hF8, 8'h80);
        repeat (3) @(negedge clk);
        ready  = 1'b1;
        m_held = 1'b0;
        repeat (3) @(negedge clk);
        chk("valid_after_release", {31'h0, o_valid}, 32'h0);

        // timeout after two digits, then a full scan in a different order -> ECAB
        present(4'b1110, 8'hF9, 10, 1);
        present(4'b1101, 8'hA4, 10, 1);
        present(4'b1111, 8'hFF, 60, 1);
        present(4'b1011, 8'hC6, 10, 1);
        present(4'b0111, 8'h86, 10, 1);
        present(4'b1110, 8'h83, 10, 1);
        present(4'b1101, 8'h88, 10, 1);

        // reset mid-frame with a held frame, then ABCD
        ready = 1'b0;
        scan4(8'hF8, 8'h92, 8'hB0, 8'hF9);
        chk("valid_before_reset", {31'h0, o_valid}, 32'h1);
        present(4'b1110, 8'hC0, 10, 1);
        present(4'b1101, 8'hC0, 10, 1);
        model_timeout(cyc, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        m_mask = 4'h0;
        m_held = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        scan4(8'h88, 8'h83, 8'hC6, 8'hA1);

        // randomized scans, glitches, bad fonts, multi-active digits and long gaps
        for (int it = 0; it < 60; it++) begin
            int ord [4];
            for (int k = 0; k < 4; k++) ord[k] = k;
            for (int k = 3; k > 0; k--) begin
                int s;
                int tmp;
                s = $urandom_range(0, k);
                tmp = ord[k];
                ord[k] = ord[s];
                ord[s] = tmp;
            end
            for (int j = 0; j < 4; j++) begin
                logic [3:0] d;
                logic [7:0] f;
                int h;
                int g;
                if ($urandom_range(0, 99) < 85) d = ~(4'(1) << ord[j]);
                else d = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) < 8)
                    f = font_tbl[$urandom_range(0, 15)] & (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h7F);
                else
                    f = 8'($urandom);
                h = ($urandom_range(0, 9) < 8) ? $urandom_range(4, 9) : $urandom_range(1, 3);
                g = ($urandom_range(0, 19) == 0) ? $urandom_range(40, 60) : $urandom_range(1, 4);
                present(d, f, h, g);
            end
        end

        repeat (TO + 20) @(negedge clk);
        model_timeout(cyc, 1'b0);
        repeat (3) @(negedge clk);

        chk("frames_outstanding", exp_q.size(), 0);
        chk("timeout_count", obs_to.size(), exp_to.size());
        for (int k = 0; k < exp_to.size() && k < obs_to.size(); k++)
            chk("timeout_cycle", obs_to[k], exp_to[k]);
        chk("overrun_count", obs_ov.size(), exp_ov.size());
        for (int k = 0; k < exp_ov.size() && k < obs_ov.size(); k++)
            chk("overrun_cycle", obs_ov[k], exp_ov[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
